// File: rtl/fir_decim_4_sched_if.sv
// Input frame stream between the upstream source and the FIR sequencer.
//   in_valid : frame valid (source -> sequencer)
//   in_data  : 4 x 18-bit signed samples, channel k at [18k+17:18k]
//   in_ready : sequencer FIFO can accept a frame (sequencer -> source)
interface fir_decim_4_sched_if;
    logic        in_valid;
    logic [71:0] in_data;
    logic        in_ready;

    modport master (output in_valid, output in_data, input in_ready);
    modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/fir_decim_4_sched.sv
// Sequencer / front end for the 4-channel decimate-by-4 FIR.
// Buffers input frames in a small FIFO, drives the FIR state counter, the
// time-multiplexed sample stream and the coefficient-set select, and
// qualifies the FIR output strobe after discarding the start-up results.
// Ports:
//   c, rn          clock (4x sample rate), async active-low reset
//   en             run enable (low -> IDLE)
//   sel_req        requested coefficient set
//   s_in           input frame stream (valid/ready, 72-bit frame)
//   state, id, sel FIR drive: state counter, sample for channel state[1:0], coef set
//   fir_ov, fir_od FIR output strobe / data
//   out_valid/out_data  qualified output strobe / registered FIR result
//   underflow      sticky: FIFO empty at a frame boundary in RUN
//   busy           high in FLUSH or RUN
module fir_decim_4_sched #(
    parameter int FIFO_DEPTH = 4,
    parameter int FLUSH_LEN  = 256,
    parameter int DISCARD    = 4
) (
    input  logic                     c,
    input  logic                     rn,
    input  logic                     en,
    input  logic                     sel_req,
    fir_decim_4_sched_if.slave       s_in,
    output logic [7:0]               state,
    output logic [17:0]              id,
    output logic                     sel,
    input  logic                     fir_ov,
    input  logic [71:0]              fir_od,
    output logic                     out_valid,
    output logic [71:0]              out_data,
    output logic                     underflow,
    output logic                     busy
);
    localparam int AW  = $clog2(FIFO_DEPTH);
    localparam int FCW = (FLUSH_LEN > 1) ? $clog2(FLUSH_LEN) : 1;
    localparam int DW  = $clog2(DISCARD + 2);

    typedef enum logic [1:0] {IDLE, FLUSH, RUN} fsm_t;

    fsm_t                r_fsm, w_nxt;
    logic [7:0]          r_state, w_st_nxt;
    logic [17:0]         r_id, w_id_nxt;
    logic                r_sel, r_out_valid, r_underflow, r_busy, r_in_ready;
    logic [71:0]         r_out_data;
    logic [FCW-1:0]      r_fcnt;
    logic [DW-1:0]       r_disc;
    logic [3:0][17:0]    r_cur;
    logic [3:0][17:0]    r_mem [FIFO_DEPTH];
    logic [AW-1:0]       r_wp, r_rp;
    logic [AW:0]         r_cnt, w_cnt_nxt;
    logic [3:0][17:0]    w_frame;
    logic                w_empty, w_push, w_pop, w_pop_edge, w_run_entry;

    always_comb begin
        w_nxt = r_fsm;
        if (!en) begin
            w_nxt = IDLE;
        end else begin
            case (r_fsm)
                IDLE:    w_nxt = FLUSH;
                FLUSH:   if (r_fcnt == FCW'(FLUSH_LEN - 1)) w_nxt = RUN;
                default: w_nxt = r_fsm;
            endcase
        end
    end

    // The edge into RUN is also a frame boundary, so the first RUN cycle
    // already presents real data to the FIR.
    assign w_run_entry = (r_fsm == FLUSH) && (w_nxt == RUN);
    assign w_pop_edge  = w_run_entry ||
                         ((r_fsm == RUN) && (w_nxt == RUN) && (r_state[1:0] == 2'd3));
    assign w_empty     = (r_cnt == '0);
    assign w_pop       = w_pop_edge && !w_empty;
    // r_in_ready is already low when full, so a push never lands on a full FIFO.
    assign w_push      = s_in.in_valid && r_in_ready;
    assign w_cnt_nxt   = r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
    assign w_frame     = w_empty ? '0 : r_mem[r_rp];

    always_comb begin
        w_st_nxt = '0;
        w_id_nxt = '0;
        if (w_nxt != IDLE && r_fsm != IDLE)
            w_st_nxt = r_state + 8'd1;
        if (w_nxt == RUN) begin
            if (w_pop_edge) w_id_nxt = w_frame[0];
            else            w_id_nxt = r_cur[w_st_nxt[1:0]];
        end
    end

    always_ff @(posedge c) begin
        if (w_push && w_nxt != IDLE)
            r_mem[r_wp] <= s_in.in_data;
    end

    always_ff @(posedge c or negedge rn) begin
        if (!rn) begin
            r_fsm       <= IDLE;
            r_state     <= '0;
            r_id        <= '0;
            r_sel       <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_underflow <= 1'b0;
            r_busy      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_fcnt      <= '0;
            r_disc      <= DW'(DISCARD);
            r_cur       <= '0;
            r_wp        <= '0;
            r_rp        <= '0;
            r_cnt       <= '0;
        end else begin
            r_fsm      <= w_nxt;
            r_state    <= w_st_nxt;
            r_id       <= w_id_nxt;
            r_busy     <= (w_nxt != IDLE);
            r_in_ready <= (w_nxt != IDLE) && (w_cnt_nxt != (AW+1)'(FIFO_DEPTH));
            r_fcnt     <= (r_fsm == FLUSH) ? r_fcnt + FCW'(1) : '0;

            if (w_nxt == IDLE) begin
                r_wp  <= '0;
                r_rp  <= '0;
                r_cnt <= '0;
            end else begin
                if (w_push) r_wp <= r_wp + AW'(1);
                if (w_pop)  r_rp <= r_rp + AW'(1);
                r_cnt <= w_cnt_nxt;
            end

            // An empty FIFO at a boundary feeds zeros; the counter never stalls.
            if (w_pop_edge) begin
                r_cur <= w_frame;
                if (w_empty) r_underflow <= 1'b1;
            end
            if (w_nxt == IDLE)
                r_underflow <= 1'b0;

            // Coefficient set only switches on a 16-cycle MAC block boundary.
            if (r_fsm == IDLE)
                r_sel <= sel_req;
            else if (r_state[3:0] == 4'hF)
                r_sel <= sel_req;

            r_out_valid <= 1'b0;
            if (r_fsm == RUN && fir_ov) begin
                r_out_data <= fir_od;
                if (r_disc != '0) r_disc <= r_disc - DW'(1);
                else              r_out_valid <= 1'b1;
            end
            if (w_run_entry)
                r_disc <= DW'(DISCARD);
        end
    end

    assign state         = r_state;
    assign id            = r_id;
    assign sel           = r_sel;
    assign out_valid     = r_out_valid;
    assign out_data      = r_out_data;
    assign underflow     = r_underflow;
    assign busy          = r_busy;
    assign s_in.in_ready = r_in_ready;
endmodule

// File: tb/tb_fir_decim_4_sched.sv
// Directed bench for fir_decim_4_sched: flush sequencing, FIFO prefill and
// back-pressure, sample streaming, underflow, sel block alignment, output
// discard, en abort and asynchronous reset.
module tb_fir_decim_4_sched;
    logic        c, rn, en, sel_req, fir_ov;
    logic [71:0] fir_od;
    logic [7:0]  state;
    logic [17:0] id;
    logic        sel, out_valid, underflow, busy;
    logic [71:0] out_data;
    int          vectors = 0;
    int          miscompares = 0;

    fir_decim_4_sched_if bus();

    fir_decim_4_sched dut (
        .c(c), .rn(rn), .en(en), .sel_req(sel_req), .s_in(bus),
        .state(state), .id(id), .sel(sel), .fir_ov(fir_ov), .fir_od(fir_od),
        .out_valid(out_valid), .out_data(out_data), .underflow(underflow), .busy(busy)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    task automatic tick();
        @(posedge c);
        #1;
    endtask

    task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [71:0] mkf(input int a, input int b, input int cc, input int d);
        return {18'(d), 18'(cc), 18'(b), 18'(a)};
    endfunction

    task automatic push(input logic [71:0] f);
        bus.in_valid = 1'b1;
        bus.in_data  = f;
    endtask

    initial begin
        rn = 1'b1; en = 1'b0; sel_req = 1'b0; fir_ov = 1'b0; fir_od = '0;
        bus.in_valid = 1'b0; bus.in_data = '0;
        #2 rn = 1'b0;
        #1;
        chk("rst_state", 72'(state), 72'd0);
        chk("rst_id", 72'(id), 72'd0);
        chk("rst_busy", 72'(busy), 72'd0);
        chk("rst_in_ready", 72'(bus.in_ready), 72'd0);
        chk("rst_out_valid", 72'(out_valid), 72'd0);
        chk("rst_out_data", out_data, 72'd0);
        chk("rst_underflow", 72'(underflow), 72'd0);
        chk("rst_sel", 72'(sel), 72'd0);
        @(posedge c); @(posedge c);
        #3 rn = 1'b1;
        tick();

        // IDLE: sel follows sel_req each edge
        sel_req = 1'b1; tick();
        chk("idle_sel_follow1", 72'(sel), 72'd1);
        sel_req = 1'b0; tick();
        chk("idle_sel_follow0", 72'(sel), 72'd0);
        chk("idle_busy", 72'(busy), 72'd0);

        // enter FLUSH
        en = 1'b1; tick();
        chk("flush_entry_busy", 72'(busy), 72'd1);
        chk("flush_entry_state", 72'(state), 72'd0);
        chk("flush_entry_in_ready", 72'(bus.in_ready), 72'd1);

        // FLUSH: count 1..255, prefill 4 frames late, then an ignored 5th push
        for (int i = 1; i <= 255; i++) begin
            case (i)
                100: begin fir_ov = 1'b1; fir_od = 72'hBAD; end
                101: fir_ov = 1'b0;
                241: push(mkf(1, 2, 3, 4));
                242: push(mkf(5, 6, 7, 8));
                243: push(mkf(9, 10, 11, 12));
                244: push(mkf(13, 14, 15, 16));
                245: push(mkf('h3AAAA, 'h3BBBB, 'h3CCCC, 'h3DDDD));
                246: bus.in_valid = 1'b0;
                default: ;
            endcase
            tick();
            chk("flush_state", 72'(state), 72'(i));
            chk("flush_id", 72'(id), 72'd0);
            chk("flush_in_ready", 72'(bus.in_ready), (i < 244) ? 72'd1 : 72'd0);
            chk("flush_out_data", out_data, 72'd0);
            chk("flush_out_valid", 72'(out_valid), 72'd0);
        end

        // RUN entry: state wraps to 0, first frame on the same edge
        tick();
        chk("run_entry_state", 72'(state), 72'd0);
        chk("run_entry_id", 72'(id), 72'd1);
        chk("run_entry_in_ready", 72'(bus.in_ready), 72'd1);
        chk("run_entry_underflow", 72'(underflow), 72'd0);

        // frames 1..5 give id = state+1; frame 6 missing -> zeros, underflow
        for (int k = 1; k <= 23; k++) begin
            if (k == 2) push(mkf(17, 18, 19, 20));
            if (k == 3) bus.in_valid = 1'b0;
            tick();
            chk("run_state", 72'(state), 72'(k));
            chk("run_id", 72'(id), (k < 20) ? 72'(k + 1) : 72'd0);
            chk("run_underflow", 72'(underflow), (k >= 20) ? 72'd1 : 72'd0);
        end

        // sel: request at [3:0]=5 deferred to 47->48; request at [3:0]=15 applied at 63->64
        for (int k = 24; k <= 64; k++) begin
            tick();
            chk("sel_state", 72'(state), 72'(k));
            chk("sel_value", 72'(sel), (k >= 48 && k < 64) ? 72'd1 : 72'd0);
            chk("sel_underflow_sticky", 72'(underflow), 72'd1);
            if (k == 37) sel_req = 1'b1;
            if (k == 63) sel_req = 1'b0;
        end

        // output qualification: first DISCARD strobes suppressed
        for (int j = 1; j <= 6; j++) begin
            fir_ov = 1'b1; fir_od = 72'(j);
            tick();
            chk("ov_valid", 72'(out_valid), (j > 4) ? 72'd1 : 72'd0);
            chk("ov_data", out_data, 72'(j));
            fir_ov = 1'b0; fir_od = 72'hFFFF;
            tick();
            chk("ov_gap_valid", 72'(out_valid), 72'd0);
            chk("ov_gap_hold", out_data, 72'(j));
        end

        // put 3 frames in the FIFO between boundaries, then drop en
        for (int n = 0; n < 4 && state[1:0] != 2'd0; n++) tick();
        chk("align_slot", 72'(state[1:0]), 72'd0);
        for (int g = 0; g < 3; g++) begin
            push(mkf('h100 + g, 'h200 + g, 'h300 + g, 'h400 + g));
            tick();
            chk("abort_fill_in_ready", 72'(bus.in_ready), 72'd1);
        end
        bus.in_valid = 1'b0;
        en = 1'b0;
        tick();
        chk("abort_busy", 72'(busy), 72'd0);
        chk("abort_state", 72'(state), 72'd0);
        chk("abort_id", 72'(id), 72'd0);
        chk("abort_in_ready", 72'(bus.in_ready), 72'd0);
        chk("abort_underflow_clr", 72'(underflow), 72'd0);
        tick();
        chk("idle_hold_state", 72'(state), 72'd0);

        // re-run with no input: a discarded FIFO shows as an empty first frame
        en = 1'b1; tick();
        chk("rerun_in_ready", 72'(bus.in_ready), 72'd1);
        repeat (255) tick();
        chk("rerun_flush_end", 72'(state), 72'd255);
        tick();
        chk("rerun_entry_state", 72'(state), 72'd0);
        chk("rerun_entry_id", 72'(id), 72'd0);
        chk("rerun_underflow", 72'(underflow), 72'd1);

        // asynchronous reset in the middle of FLUSH
        sel_req = 1'b1; en = 1'b0; tick();
        tick();
        chk("idle2_sel", 72'(sel), 72'd1);
        en = 1'b1; tick();
        repeat (50) tick();
        chk("mid_flush_state", 72'(state), 72'd50);
        chk("mid_flush_busy", 72'(busy), 72'd1);
        #3 rn = 1'b0;
        #1;
        chk("async_state", 72'(state), 72'd0);
        chk("async_busy", 72'(busy), 72'd0);
        chk("async_in_ready", 72'(bus.in_ready), 72'd0);
        chk("async_sel", 72'(sel), 72'd0);
        chk("async_out_data", out_data, 72'd0);
        chk("async_id", 72'(id), 72'd0);
        #2 rn = 1'b1;
        en = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fir_decim_4_sched.md
Name: fir_decim_4_sched

Overview:
- Sequencer and front end for the 4-channel decimate-by-4 FIR.
- Accepts parallel 4-channel input frames through a valid/ready handshake and buffers them in a small frame FIFO.
- Drives the FIR's free-running state counter, time-multiplexed id sample stream and coefficient-set select (sel).
- Qualifies the FIR's od/ov outputs into a clean out_valid stream, discarding the pipeline-flush results after start-up.

Parameters:
FIFO_DEPTH, 4, frame FIFO depth in frames (power of 2, min 2)
FLUSH_LEN, 256, cycles of zero samples written after enable to clear filter history RAM
DISCARD, 4, number of ov pulses suppressed after entering RUN

Ports:
c  input  1  clock (4 x input sample rate)
rn  input  1  asynchronous active-low reset
en  input  1  run enable; low returns to IDLE
sel_req  input  1  requested coefficient set (0 = 5 MHz, 1 = 4 MHz)
in_valid  input  1  input frame valid
in_data  input  72  frame; channel k at [18k+17:18k], signed
in_ready  output  1  FIFO can accept a frame
state  output  8  FIR state counter; [1:0] = channel, [7:2] = sample slot
id  output  18  time-multiplexed sample for channel state[1:0]
sel  output  1  coefficient set applied to FIR
fir_ov  input  1  FIR output strobe
fir_od  input  72  FIR output data
out_valid  output  1  qualified output strobe (1 cycle)
out_data  output  72  registered FIR result
underflow  output  1  sticky: FIFO empty at a frame boundary in RUN
busy  output  1  high in FLUSH or RUN

Behaviour:
- Reset (rn low, asynchronous): FSM = IDLE; state, id, sel, out_valid, out_data, underflow, busy, in_ready = 0; FIFO emptied; discard counter = DISCARD.
- All outputs are registered. state and id change on the same edge, so the FIR sees a consistent {state, id} pair each cycle.
- FSM IDLE:
  - state held at 0, id = 0, in_ready = 0, FIFO held empty.
  - sel follows sel_req directly.
  - underflow cleared.
  - en = 1 -> FLUSH.
- FSM FLUSH:
  - state increments by 1 every cycle (8-bit wrap); id = 0.
  - in_ready = not full, so upstream may prefill the FIFO.
  - After FLUSH_LEN cycles (state wraps 255 -> 0 when FLUSH_LEN = 256) -> RUN.
  - The discard counter is loaded with DISCARD on entry to RUN.
- FSM RUN:
  - state increments every cycle.
  - Frame pop occurs on the edge where state[1:0] goes 3 -> 0. The popped frame becomes the current frame, and id = current frame channel state[1:0].
  - If the FIFO is empty at a pop edge: the current frame becomes all zeros and underflow is set; the counter never stalls.
- en = 0 in any state -> IDLE on the next edge. This aborts FLUSH/RUN mid-operation and discards FIFO contents.
- FIFO:
  - Push when in_valid && in_ready.
  - in_ready = !full outside IDLE.
  - Simultaneous push and pop when full: pop first, so the push is accepted only if in_ready was high that cycle.
  - Pushes while in_ready = 0 are ignored; upstream must hold the frame.
- sel:
  - In FLUSH/RUN, sel_req is sampled and sel updates only on the edge where state[3:0] goes 15 -> 0, so each 16-cycle MAC block uses one coefficient set.
  - Changes of sel_req mid-block are deferred to the next block.
- Output:
  - On fir_ov = 1 in RUN: out_data <= fir_od.
  - If the discard counter is nonzero, decrement it and keep out_valid = 0; otherwise out_valid = 1 for one cycle.
  - fir_ov in IDLE/FLUSH is ignored.
  - out_data is held between strobes.
- busy = (FSM != IDLE).

Test Plan:
- Reset then en = 1 -> busy = 1; state counts 0..255 with id = 0; at 256th edge RUN entered, state = 0; in_ready = 1 throughout FLUSH.
- Prefill 2 frames (ch0..3 = 1, 2, 3, 4 then 5, 6, 7, 8), then stream one frame per 4 cycles -> id sequence 1, 2, 3, 4, 5, 6, 7, 8 aligned to state[1:0] = 0..3; underflow stays 0.
- Stop input in RUN -> at next state[1:0] 3->0 edge, id = 0 for 4 cycles and underflow = 1 (sticky until en = 0).
- Toggle sel_req at state[3:0] = 5 -> sel changes only on the next 15->0 edge; second toggle at state[3:0] = 15 in the same cycle as the edge -> sampled value applied.
- Pulse fir_ov 6 times in RUN with fir_od = 1..6 -> first 4 suppressed; out_valid pulses with out_data = 5 then 6; FIFO full (4 frames, no pops in FLUSH) -> in_ready = 0, extra push ignored.
- Drop en mid-RUN with FIFO holding 3 frames -> next edge IDLE, state = 0, in_ready = 0, FIFO empty; assert rn low mid-FLUSH -> all outputs 0 immediately, without waiting for a clock edge.
